// File: rtl/cv32e40s_obi_sec_responder_pkg.sv
// Purpose : shared types for the secure OBI responder (security level, response entry, parity helper).
// Latency : n/a (types and a pure combinational function only).
// Backpressure : n/a.
package cv32e40s_obi_sec_responder_pkg;

  typedef enum logic {
    NONSECURE = 1'b0,
    SECURE    = 1'b1
  } security_lvl_t;

  // One buffered response as seen by the requester.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_entry_t;

  // Odd parity per byte: the check bit makes the byte plus check bit contain an odd number of ones.
  function automatic logic [3:0] odd_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ~^d[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/cv32e40s_obi_sec_responder_if.sv
// Purpose : OBI request/response bundle between the core (master) and the secure responder (slave).
// Latency : n/a (wires only).
// Backpressure : request side stalls on gnt=0, response side holds while rvalid && !rready.
interface cv32e40s_obi_sec_responder_if;
  import cv32e40s_obi_sec_responder_pkg::*;

  logic          req;
  logic          gnt;
  logic [31:0]   addr;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata;
  security_lvl_t sec_lvl;
  logic [3:0]    wchk;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic          err;
  logic [3:0]    rchk;

  modport master (
    output req, addr, we, be, wdata, sec_lvl, wchk, rready,
    input  gnt, rvalid, rdata, err, rchk
  );

  modport slave (
    input  req, addr, we, be, wdata, sec_lvl, wchk, rready,
    output gnt, rvalid, rdata, err, rchk
  );

endinterface

// File: rtl/cv32e40s_obi_sec_responder_fifo.sv
// Purpose : synchronous FIFO of response entries (push/pop/full/empty/cnt), same-cycle push+pop legal.
// Latency : a pushed entry is visible at the head the cycle after the push.
// Backpressure : none internally; the owner must never push when full (credit-limited upstream).
module cv32e40s_obi_resp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 push_dat,
  input  logic             pop,
  output T                 head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);

  T                 store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= push_dat;
  end

  assign head  = store[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

endmodule

// File: rtl/cv32e40s_obi_sec_responder.sv
// Purpose : OBI responder fronting a 1-cycle SRAM with a secure address window; faults are answered locally.
//           Ports: clk, rst (sync, active-high), obi (slave modport), mem_* SRAM port.
//           Optional feature macro: CV32E40S_OBI_RESP_INTEGRITY_EN (write parity check, read parity generation).
// Latency : 1 cycle grant->rvalid when the response FIFO is empty; otherwise in grant order behind buffered entries.
// Backpressure : rready=0 buffers responses; gnt drops once DEPTH responses are outstanding.
module cv32e40s_obi_sec_responder
  import cv32e40s_obi_sec_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] SEC_START = 32'h0000_0800,
  parameter logic [31:0] SEC_END   = 32'h0000_0FFF,
  parameter int unsigned DEPTH     = 2,
  localparam int unsigned ADDR_W   = $clog2(MEM_WORDS)
) (
  input  logic                         clk,
  input  logic                         rst,
  cv32e40s_obi_sec_responder_if.slave  obi,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
  localparam logic [33:0] MEM_BYTES = 34'(MEM_WORDS) << 2;

  // Decode in 34 bits so BASE_ADDR + size can never wrap back into range.
  logic [33:0] addr_w;
  logic [33:0] off;
  logic        in_range;
  logic        in_sec;
  logic        wchk_err;
  logic        acc_err;

  assign addr_w   = {2'b00, obi.addr[31:2], 2'b00};
  assign off      = addr_w - {2'b00, BASE_ADDR};
  assign in_range = (addr_w >= {2'b00, BASE_ADDR}) && (off < MEM_BYTES);
  assign in_sec   = (addr_w >= {2'b00, SEC_START}) && (addr_w <= {2'b00, SEC_END});
  assign acc_err  = !in_range || (in_sec && (obi.sec_lvl != SECURE)) || wchk_err;

  // Credit: everything granted and not yet accepted sits in the pipe or the FIFO.
  logic             pipe_v;
  logic             pipe_we;
  logic             pipe_err;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   outstanding;

  assign outstanding = {1'b0, fifo_cnt} + (CNT_W + 1)'(pipe_v);
  assign obi.gnt     = obi.req && !rst && (outstanding < (CNT_W + 1)'(DEPTH));

  assign mem_req_o   = obi.gnt && !acc_err;
  assign mem_we_o    = obi.we;
  assign mem_be_o    = obi.be;
  assign mem_addr_o  = off[ADDR_W+1:2];
  assign mem_wdata_o = obi.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v   <= 1'b0;
      pipe_we  <= 1'b0;
      pipe_err <= 1'b0;
    end else begin
      pipe_v <= obi.gnt;
      if (obi.gnt) begin
        pipe_we  <= obi.we;
        pipe_err <= acc_err;
      end
    end
  end

  obi_resp_entry_t pipe_entry;
  obi_resp_entry_t fifo_head;
  obi_resp_entry_t resp;
  logic            fifo_empty;
  logic            fifo_full_unused;
  logic            push;
  logic            pop;

  // SRAM data is only meaningful for a successful read in the cycle after its strobe.
  assign pipe_entry.rdata = (!pipe_we && !pipe_err) ? mem_rdata_i : 32'h0;
  assign pipe_entry.err   = pipe_err;

  // Bypass: an empty FIFO lets the pipe entry answer directly; it is only buffered if not taken now.
  assign resp       = fifo_empty ? pipe_entry : fifo_head;
  assign obi.rvalid = pipe_v || !fifo_empty;
  assign obi.rdata  = resp.rdata;
  assign obi.err    = resp.err;
  assign push       = pipe_v && !(fifo_empty && obi.rready);
  assign pop        = !fifo_empty && obi.rready;

  cv32e40s_obi_resp_fifo #(
    .DEPTH (DEPTH),
    .T     (obi_resp_entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (pipe_entry),
    .pop      (pop),
    .head     (fifo_head),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );

`ifdef CV32E40S_OBI_RESP_INTEGRITY_EN
  // Only enabled bytes of a write are checked; reads carry no write parity.
  assign wchk_err = obi.we && |(obi.be & (obi.wchk ^ odd_parity(obi.wdata)));
  assign obi.rchk = odd_parity(resp.rdata);
`else
  logic unused_wchk;
  assign unused_wchk = ^obi.wchk;
  assign wchk_err    = 1'b0;
  assign obi.rchk    = 4'b0;
`endif

endmodule

// File: tb/tb_cv32e40s_obi_sec_responder.sv
module tb_cv32e40s_obi_sec_responder;
  import cv32e40s_obi_sec_responder_pkg::*;

  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned AW        = 10;
  localparam int unsigned DEPTH     = 2;
  localparam longint unsigned BASE  = 64'h0;
  localparam longint unsigned SSTART = 64'h800;
  localparam longint unsigned SEND   = 64'hFFF;

  logic clk = 1'b0;
  logic rst;
  logic load;
  always #5 clk = ~clk;

  cv32e40s_obi_sec_responder_if obi();

  logic          mem_req_o;
  logic          mem_we_o;
  logic [3:0]    mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [31:0]   mem_rdata;

  cv32e40s_obi_sec_responder #(
    .MEM_WORDS (MEM_WORDS),
    .BASE_ADDR (32'h0000_0000),
    .SEC_START (32'h0000_0800),
    .SEC_END   (32'h0000_0FFF),
    .DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .obi         (obi.slave),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'hDEAD_BEEF;
    if (i == 32'h10) return 32'h0000_0001;
    return 32'hA500_0000 | 32'(i);
  endfunction

  function automatic logic [3:0] tb_par(input logic [31:0] d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ~^d[8*i +: 8];
    return r;
  endfunction

  // SRAM macro model: 1-cycle read latency, byte-enabled writes.
  logic [31:0] sram [MEM_WORDS];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        for (int i = 0; i < 4; i++)
          if (mem_be_o[i]) sram[mem_addr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  // Reference model: ordered queue of expected responses plus an independent memory image.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t       exp_q[$];
  logic [31:0] ref_mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  logic        got_gnt, got_mreq, got_rvalid, got_err, exp_gnt;
  logic [31:0] got_rdata;
  logic [3:0]  got_rchk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic [31:0] a, input logic w, input logic [3:0] b,
                                       input logic [31:0] wd, input logic [3:0] wc, input logic s);
    longint unsigned aw;
    logic f;
    aw = {32'b0, a[31:2], 2'b00};
    f  = !(aw >= BASE && aw < BASE + MEM_WORDS * 4) || ((aw >= SSTART && aw <= SEND) && !s);
`ifdef CV32E40S_OBI_RESP_INTEGRITY_EN
    if (w) for (int i = 0; i < 4; i++) if (b[i] && (wc[i] != ~^wd[8*i +: 8])) f = 1'b1;
`else
    if (w && (b == 4'hF) && (wc == 4'hF)) f = f;
`endif
    return f;
  endfunction

  // One bus cycle: drive at negedge, check 1 time unit later, update the model at posedge.
  task automatic cycle(input logic rq, input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] wd, input logic s, input logic [3:0] flip,
                       input logic rr, input logic r);
    logic        f;
    logic        e_rv;
    resp_t       e;
    logic [3:0]  wc;
    longint unsigned idx;
    @(negedge clk);
    wc          = tb_par(wd) ^ flip;
    rst         = r;
    obi.req     = rq;
    obi.addr    = a;
    obi.we      = w;
    obi.be      = b;
    obi.wdata   = wd;
    obi.sec_lvl = s ? SECURE : NONSECURE;
    obi.wchk    = wc;
    obi.rready  = rr;
    #1;
    f       = model_fault(a, w, b, wd, wc, s);
    exp_gnt = !r && rq && (exp_q.size() < DEPTH);
    e_rv    = (exp_q.size() > 0);
    idx     = ({32'b0, a[31:2], 2'b00} - BASE) / 4;
    got_gnt    = obi.gnt;
    got_mreq   = mem_req_o;
    got_rvalid = obi.rvalid;
    got_rdata  = obi.rdata;
    got_err    = obi.err;
    got_rchk   = obi.rchk;
    chk("gnt", 32'(got_gnt), 32'(exp_gnt));
    chk("mem_req", 32'(got_mreq), 32'(exp_gnt && !f));
    if (exp_gnt && !f) chk("mem_addr", 32'(mem_addr_o), 32'(idx));
    chk("rvalid", 32'(got_rvalid), 32'(e_rv));
    if (e_rv) begin
      chk("rdata", got_rdata, exp_q[0].rdata);
      chk("err", 32'(got_err), 32'(exp_q[0].err));
`ifdef CV32E40S_OBI_RESP_INTEGRITY_EN
      chk("rchk", 32'(got_rchk), 32'(tb_par(exp_q[0].rdata)));
`else
      chk("rchk", 32'(got_rchk), 32'h0);
`endif
    end
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (e_rv && rr) void'(exp_q.pop_front());
      if (exp_gnt) begin
        e.err   = f;
        e.rdata = (!w && !f) ? ref_mem[idx] : 32'h0;
        if (w && !f)
          for (int i = 0; i < 4; i++) if (b[i]) ref_mem[idx][8*i +: 8] = wd[8*i +: 8];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, rr, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic s, input logic rr);
    cycle(1'b1, a, 1'b0, 4'hF, 32'h0, s, 4'h0, rr, 1'b0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        sec;
    logic        exp_mreq;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[15];

  logic        p_req;
  logic [31:0] p_addr, p_wdata;
  logic        p_we, p_sec, rr_r;
  logic [3:0]  p_be, p_flip;
  logic [31:0] bnd [8];

  initial begin
    vecs[0]  = '{32'h0000_0100, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0800, 1'b1, 4'hF, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{32'h0000_0800, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0, 32'hA500_0200};
    vecs[3]  = '{32'h0000_07FC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA500_01FF};
    vecs[4]  = '{32'h0000_0800, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{32'h0000_0FFC, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{32'h0000_0FFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0, 32'hA500_03FF};
    vecs[7]  = '{32'h0000_1000, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0};
    vecs[9]  = '{32'h0000_0104, 1'b1, 4'h3, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{32'h0000_0104, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA500_F00D};
    vecs[11] = '{32'h0000_0906, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[12] = '{32'h0000_0904, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1122_3344};
    vecs[13] = '{32'h0000_0040, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_0001};
    vecs[14] = '{32'h0000_07FF, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA500_01FF};
    bnd = '{32'h7FC, 32'h800, 32'hFFC, 32'h1000, 32'h0, 32'hFFFF_FFFC, 32'h7F8, 32'h804};
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);

    // Reset: grant held low even with a request present.
    load = 1'b1;
    cycle(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    load = 1'b0;
    cycle(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("reset_gnt", 32'(got_gnt), 32'h0);
    chk("reset_rvalid", 32'(got_rvalid), 32'h0);
    idle(1'b1);

    // Directed vectors, one isolated transaction each.
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata, vecs[i].sec, 4'h0, 1'b1, 1'b0);
      chk($sformatf("vec%0d_gnt", i), 32'(got_gnt), 32'h1);
      chk($sformatf("vec%0d_mreq", i), 32'(got_mreq), 32'(vecs[i].exp_mreq));
      idle(1'b1);
      chk($sformatf("vec%0d_rvalid", i), 32'(got_rvalid), 32'h1);
      chk($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
    end

    // Back-pressure: two granted, third held until one credit is returned.
    rd(32'h100, 1'b0, 1'b0); chk("bp_gnt1", 32'(got_gnt), 32'h1);
    rd(32'h7FC, 1'b0, 1'b0); chk("bp_gnt2", 32'(got_gnt), 32'h1);
    chk("bp_bypass_data", got_rdata, 32'hDEAD_BEEF);
    rd(32'h104, 1'b0, 1'b0); chk("bp_gnt3_held", 32'(got_gnt), 32'h0);
    rd(32'h104, 1'b0, 1'b0); chk("bp_hold_data", got_rdata, 32'hDEAD_BEEF);
    rd(32'h104, 1'b0, 1'b1); chk("bp_pop_nocredit", 32'(got_gnt), 32'h0);
    chk("bp_first", got_rdata, 32'hDEAD_BEEF);
    rd(32'h104, 1'b0, 1'b1); chk("bp_gnt3", 32'(got_gnt), 32'h1);
    chk("bp_second", got_rdata, 32'hA500_01FF);
    idle(1'b1); chk("bp_third", got_rdata, 32'hA500_F00D);
    idle(1'b1); chk("bp_empty", 32'(got_rvalid), 32'h0);

    // Reset with two responses buffered: they vanish.
    rd(32'h100, 1'b0, 1'b0);
    rd(32'h7FC, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b1, 32'h7FC, 1'b0, 4'hF, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1);
    chk("rst_mid_gnt", 32'(got_gnt), 32'h0);
    rd(32'h100, 1'b0, 1'b1);
    chk("rst_mid_rvalid", 32'(got_rvalid), 32'h0);
    idle(1'b1); chk("rst_fresh", got_rdata, 32'hDEAD_BEEF);
    idle(1'b1); chk("rst_no_stale", 32'(got_rvalid), 32'h0);

`ifdef CV32E40S_OBI_RESP_INTEGRITY_EN
    cycle(1'b1, 32'h908, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 4'b0100, 1'b1, 1'b0);
    chk("par_mreq", 32'(got_mreq), 32'h0);
    idle(1'b1); chk("par_err", 32'(got_err), 32'h1);
    rd(32'h908, 1'b1, 1'b1);
    idle(1'b1); chk("par_unchanged", got_rdata, 32'hA500_0242);
    rd(32'h40, 1'b0, 1'b1);
    idle(1'b1); chk("par_rchk", 32'(got_rchk), 32'h0000_000E);
`endif

    // Randomized traffic; a request is held until granted.
    p_req = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!p_req && ($urandom_range(0, 9) < 7)) begin
        p_req   = 1'b1;
        p_addr  = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 7)] : 32'($urandom_range(0, 32'h11FF));
        p_we    = ($urandom_range(0, 2) == 0);
        p_be    = 4'($urandom);
        p_wdata = $urandom;
        p_sec   = 1'($urandom);
        p_flip  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      end
      rr_r = ($urandom_range(0, 3) != 0);
      cycle(p_req, p_addr, p_we, p_be, p_wdata, p_sec, p_flip, rr_r, 1'b0);
      if (exp_gnt) p_req = 1'b0;
    end
    for (int n = 0; n < 6; n++) idle(1'b1);
    chk("drain_rvalid", 32'(got_rvalid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
